// File: rtl/alu_nibble_sequencer.sv
// Runs one W-bit ALU operation through an external 4-bit 74181-style slice,
// one nibble per clock (LSN first), chaining the active-low carry between nibbles.
module alu_nibble_sequencer #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*NIB-1:0] op_a,
  input  logic [4*NIB-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cin_n,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_ci_n,
  input  logic [3:0]       alu_y,
  input  logic             alu_co_n,
  input  logic             alu_aeqb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*NIB-1:0] res_y,
  output logic             res_co_n,
  output logic             res_aeqb
);

  localparam int W = 4 * NIB;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [3:0]   idx;
  logic [W-1:0] a_r, b_r, res_y_r;
  logic [3:0]   s_r;
  logic         m_r, carry_n, aeqb_acc;
  logic [3:0]   a_nib, b_nib;
  logic         accept, last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == 4'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Slice drive is decoded purely from registered state, never from in_*.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_s     = 4'h0;
    alu_m     = 1'b0;
    alu_ci_n  = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        alu_a    = a_nib;
        alu_b    = b_nib;
        alu_s    = s_r;
        alu_m    = m_r;
        alu_ci_n = carry_n;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int k = 0; k < NIB; k++) begin
      if (idx == 4'(k)) begin
        a_nib = a_r[4*k +: 4];
        b_nib = b_r[4*k +: 4];
      end
    end
  end

  // Operand capture
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= op_a;
      b_r <= op_b;
    end
  end

  // Nibble sequencing, carry chain and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 4'd0;
      carry_n  <= 1'b1;
      aeqb_acc <= 1'b0;
      res_y_r  <= '0;
      s_r      <= 4'h0;
      m_r      <= 1'b0;
    end else if (accept) begin
      idx      <= 4'd0;
      carry_n  <= op_cin_n;
      aeqb_acc <= 1'b1;
      s_r      <= op_s;
      m_r      <= op_m;
    end else if (state == RUN) begin
      carry_n  <= alu_co_n;
      aeqb_acc <= aeqb_acc & alu_aeqb;
      for (int k = 0; k < NIB; k++) begin
        if (idx == 4'(k)) res_y_r[4*k +: 4] <= alu_y;
      end
      idx <= last ? 4'd0 : idx + 4'd1;
    end
  end

  // Logic mode has no meaningful carry, so the final carry reads as inactive.
  assign res_y    = res_y_r;
  assign res_co_n = m_r | carry_n;
  assign res_aeqb = aeqb_acc;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Randomized self-checking bench for alu_nibble_sequencer with a behavioural
// 74181 slice on the alu_* ports and a whole-word reference model.
module tb_alu_nibble_sequencer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   op_s;
  logic         op_m, op_cin_n;
  logic [3:0]   alu_a, alu_b, alu_s, alu_y;
  logic         alu_m, alu_ci_n, alu_co_n, alu_aeqb;
  logic         out_valid, out_ready;
  logic [W-1:0] res_y;
  logic         res_co_n, res_aeqb;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIB(NIB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin_n(op_cin_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_ci_n(alu_ci_n),
    .alu_y(alu_y), .alu_co_n(alu_co_n), .alu_aeqb(alu_aeqb),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_y(res_y), .res_co_n(res_co_n), .res_aeqb(res_aeqb)
  );

  // 74181 logic-mode functions, bitwise so usable at any width up to 16
  function automatic logic [15:0] lfun(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      4'h0: lfun = ~a;
      4'h1: lfun = ~(a | b);
      4'h2: lfun = ~a & b;
      4'h3: lfun = 16'h0000;
      4'h4: lfun = ~(a & b);
      4'h5: lfun = ~b;
      4'h6: lfun = a ^ b;
      4'h7: lfun = a & ~b;
      4'h8: lfun = ~a | b;
      4'h9: lfun = ~(a ^ b);
      4'hA: lfun = b;
      4'hB: lfun = a & b;
      4'hC: lfun = 16'hFFFF;
      4'hD: lfun = a | ~b;
      4'hE: lfun = a | b;
      default: lfun = a;
    endcase
  endfunction

  // Arithmetic mode: F = (A | S0&B | S1&~B) + (S3&A&B | S2&A&~B) + carry
  function automatic logic [15:0] xterm(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    xterm = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
  endfunction

  function automatic logic [15:0] yterm(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    yterm = (a & b & {16{s[3]}}) | (a & ~b & {16{s[2]}});
  endfunction

  logic [15:0] sl_x, sl_y, sl_l;
  logic [4:0]  sl_sum;
  always_comb begin
    sl_x     = xterm(alu_s, {12'h0, alu_a}, {12'h0, alu_b});
    sl_y     = yterm(alu_s, {12'h0, alu_a}, {12'h0, alu_b});
    sl_l     = lfun(alu_s, {12'h0, alu_a}, {12'h0, alu_b});
    sl_sum   = {1'b0, sl_x[3:0]} + {1'b0, sl_y[3:0]} + {4'h0, ~alu_ci_n};
    alu_co_n = ~sl_sum[4];
    alu_y    = alu_m ? sl_l[3:0] : sl_sum[3:0];
    alu_aeqb = (alu_y == 4'hF);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [W-1:0] e_a, e_b, e_y;
  logic [3:0]   e_s;
  logic         e_m, e_cin, e_con, e_aeqb;
  logic         e_ci [NIB];

  // Whole-word reference: the nibble chain must equal one W-bit operation.
  task automatic present(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] s, input logic m, input logic cin_n);
    logic [16:0] x17, y17, sum17, mask, part;
    logic [15:0] lf;
    op_a = a; op_b = b; op_s = s; op_m = m; op_cin_n = cin_n; in_valid = 1'b1;
    e_a = a; e_b = b; e_s = s; e_m = m; e_cin = cin_n;
    x17   = {1'b0, xterm(s, a, b)};
    y17   = {1'b0, yterm(s, a, b)};
    sum17 = x17 + y17 + {16'h0, ~cin_n};
    lf    = lfun(s, a, b);
    e_y    = m ? lf : sum17[15:0];
    e_con  = m ? 1'b1 : ~sum17[16];
    e_aeqb = (e_y == 16'hFFFF);
    e_ci[0] = cin_n;
    for (int k = 1; k < NIB; k++) begin
      mask    = (17'd1 << (4 * k)) - 17'd1;
      part    = (x17 & mask) + (y17 & mask) + {16'h0, ~cin_n};
      e_ci[k] = ~part[4*k];
    end
  endtask

  task automatic wait_accept(input string tag);
    int budget;
    budget = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_check(input string tag);
    logic [W-1:0] sa, sb;
    for (int k = 0; k < NIB; k++) begin
      sa = e_a >> (4 * k);
      sb = e_b >> (4 * k);
      chk($sformatf("%s_drv%0d", tag, k),
          {in_ready, out_valid, alu_a, alu_b, alu_s, alu_m, alu_ci_n},
          {1'b0, 1'b0, sa[3:0], sb[3:0], e_s, e_m, e_ci[k]});
      @(negedge clk);
    end
    chk({tag, "_y"}, res_y, e_y);
    chk({tag, "_flags"}, {out_valid, in_ready, res_co_n, res_aeqb},
        {1'b1, 1'b0, e_con, e_aeqb});
  endtask

  task automatic drain(input string tag, input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("%s_hold%0d", tag, h),
          {out_valid, in_ready, res_co_n, res_aeqb, res_y},
          {1'b1, 1'b0, e_con, e_aeqb, e_y});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, {out_valid, in_ready, res_co_n, res_aeqb, res_y, alu_a, alu_b, alu_s, alu_m, alu_ci_n},
        {1'b0, 1'b1, e_con, e_aeqb, e_y, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1});
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s, input logic m, input logic cin_n, input int hold);
    present(a, b, s, m, cin_n);
    wait_accept(tag);
    run_check(tag);
    drain(tag, hold);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_s = 4'h0; op_m = 1'b0; op_cin_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out", {in_ready, out_valid, res_co_n, res_aeqb, res_y}, {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});
    chk("reset_alu", {alu_a, alu_b, alu_s, alu_m, alu_ci_n}, {4'h0, 4'h0, 4'h0, 1'b0, 1'b1});
    rst = 1'b0;
    @(negedge clk);

    do_op("add",   16'h1234, 16'h0FCC, 4'b1001, 1'b0, 1'b1, 0);
    do_op("wrap",  16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1);
    do_op("cmpeq", 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 0);
    do_op("cmpne", 16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b1, 0);
    do_op("xor",   16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 0);

    // Backpressure with a second request already pending during DONE
    present(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1);
    wait_accept("b2b1");
    run_check("b2b1");
    op_a = 16'h5000; op_b = 16'h1000; op_s = 4'b0110; op_m = 1'b0; op_cin_n = 1'b0;
    in_valid = 1'b1;
    drain("b2b1", 5);
    present(16'h5000, 16'h1000, 4'b0110, 1'b0, 1'b0);
    wait_accept("b2b2");
    run_check("b2b2");
    drain("b2b2", 0);

    // Reset during RUN cycle 2
    present(16'hABCD, 16'h1357, 4'b1001, 1'b0, 1'b0);
    wait_accept("rstrun");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstrun_out", {in_ready, out_valid, res_co_n, res_aeqb, res_y}, {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});
    chk("rstrun_alu", {alu_a, alu_b, alu_s, alu_m, alu_ci_n}, {4'h0, 4'h0, 4'h0, 1'b0, 1'b1});
    do_op("after_rst", 16'h5000, 16'h1000, 4'b0110, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
